flappy_game_engine: RTL
=======================

Name: flappy_game_engine

Overview:
Game-state core for the pitch-controlled flappy game. It scrolls N_PIPES obstacles at a fixed speed, re-spawns each with an LFSR-chosen gap, counts passed pipes, detects bird/pipe/floor collisions and sequences IDLE/PLAYING/OVER. It runs on the system clock, is advanced by a one-cycle tick enable instead of a derived clock, and feeds the collision-free renderer and the VGA colour mux in the top level.

Parameters:
N_PIPES, 3, number of simultaneous pipes
SCREEN_W, 640, visible width in pixels
SCREEN_H, 480, visible height in pixels
PIPE_W, 50, pipe width; pipe occupies x in [pipe_x, pipe_x+PIPE_W-1]
PIPE_SPACING, 220, horizontal distance between consecutive pipes; N_PIPES*PIPE_SPACING >= SCREEN_W
GAP_H, 120, gap height
GAP_MARGIN, 40, minimum gap_top; GAP_MARGIN+255+GAP_H <= SCREEN_H
BIRD_X, 100, bird left edge
BIRD_SIZE, 20, bird square side
SPEED, 4, pixels moved per tick; SPEED < PIPE_SPACING
LFSR_SEED, 16'hACE1, LFSR reset value (non-zero)
SCORE_W, 8, score width

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
tick  in  1  one-cycle game-step pulse
start  in  1  start button, active-high level
bird_y  in  10  bird top edge (from microphone block)
pipe_x  out  11*N_PIPES  pipe left edges, pipe i at bits [11i+10:11i]
pipe_gap_top  out  10*N_PIPES  gap top y, pipe i at bits [10i+9:10i]
state  out  2  0=IDLE, 1=PLAYING, 2=OVER
score  out  SCORE_W  pipes passed, saturating
collided  out  1  registered collision flag

Behaviour:
- Reset (sync): state=IDLE, score=0, collided=0, LFSR=LFSR_SEED, pipe_x[i]=SCREEN_W+i*PIPE_SPACING, gap_top[i]=SCREEN_H/2-GAP_H/2. start edge register cleared.
- start_edge = start & ~start_q (start_q registered each cycle).
- IDLE: pipes, score, LFSR frozen; tick ignored. start_edge -> PLAYING; in that same edge reload pipes, gap_tops, score=0, collided=0 to reset values (LFSR keeps running value).
- PLAYING, per cycle: hit = floor | any pipe_hit[i]. floor = bird_y+BIRD_SIZE > SCREEN_H. pipe_hit[i] = x-overlap (pipe_x <= BIRD_X+BIRD_SIZE-1 and pipe_x+PIPE_W-1 >= BIRD_X) and not in gap (bird_y < gap_top or bird_y+BIRD_SIZE > gap_top+GAP_H). All compares are 12-bit unsigned on registered pipe state.
- hit -> next edge state=OVER, collided=1; pipe movement suppressed that cycle even if tick=1 (collision priority).
- tick & ~hit: LFSR steps once (Fibonacci, taps 16,14,13,11). Each pipe: if pipe_x < SPEED, respawn pipe_x = pipe_x + N_PIPES*PIPE_SPACING - SPEED, gap_top = GAP_MARGIN + LFSR_current[7:0]; else pipe_x -= SPEED. Multiple respawns on one tick all use the same LFSR value.
- Score: on tick, for each pipe with old right edge (pipe_x+PIPE_W) >= BIRD_X and new right edge < BIRD_X, score += 1 (sum over pipes), saturating at 2^SCORE_W-1.
- OVER: pipes, score, LFSR frozen; collided held 1; start_edge -> IDLE (collided stays until PLAYING entry).
- start held high produces one edge only. Reset mid-game returns every register to reset values on the next edge.
- Outputs are direct register values; no combinational path from inputs to outputs.

Test Plan:
- Reset asserted 2 cycles -> state=0, score=0, pipe_x={640,860,1080}, gap_top=180 all, collided=0.
- start pulse, bird_y=230 held, 10 ticks -> state=1, pipe_x={600,820,1040}, collided=0; ticks before start leave pipe_x unchanged.
- bird_y=230, 161 ticks -> pipe0 respawns to 656 (220 beyond pipe2 at 436), gap_top0 = 40+LFSR[7:0] matching a bench LFSR model; score=1 after tick 148 (pipe_x 52->48).
- bird_y=10, ticks -> tick 131 gives pipe0 x=116, next cycle state=2, collided=1; further ticks leave pipe_x=116, score=0; start edge -> IDLE, second edge -> PLAYING with reset positions.
- bird_y=470 at PLAYING entry -> OVER on next cycle (floor); tick coincident with hit -> no pipe movement.
- Reset asserted mid-PLAYING with score=3 -> next cycle all reset values; score saturation checked with SCORE_W=2 (stays 3).

Source files
------------

// File: rtl/flappy_game_engine.sv
// Game-state core: scrolls N_PIPES obstacles, respawns them with LFSR gaps,
// scores passed pipes, detects bird/pipe/floor hits and runs IDLE/PLAYING/OVER.
// Latency: one cycle from tick/start/bird_y to registered outputs. There is no backpressure.
// Ports: clk, reset (sync, active-high), tick (game-step enable), start (level button),
//   bird_y (bird top edge) -> pipe_x / pipe_gap_top (packed per pipe), state, score, collided.
module flappy_game_engine #(
  parameter int          N_PIPES      = 3,
  parameter int          SCREEN_W     = 640,
  parameter int          SCREEN_H     = 480,
  parameter int          PIPE_W       = 50,
  parameter int          PIPE_SPACING = 220,
  parameter int          GAP_H        = 120,
  parameter int          GAP_MARGIN   = 40,
  parameter int          BIRD_X       = 100,
  parameter int          BIRD_SIZE    = 20,
  parameter int          SPEED        = 4,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1,
  parameter int          SCORE_W      = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tick,
  input  logic                  start,
  input  logic [9:0]            bird_y,
  output logic [11*N_PIPES-1:0] pipe_x,
  output logic [10*N_PIPES-1:0] pipe_gap_top,
  output logic [1:0]            state,
  output logic [SCORE_W-1:0]    score,
  output logic                  collided
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PLAYING = 2'd1,
    ST_OVER    = 2'd2
  } state_t;

  // Pass-count width, and a sum width that cannot overflow before saturation.
  localparam int CW    = $clog2(N_PIPES + 1);
  localparam int SUM_W = SCORE_W + CW + 1;

  localparam logic [11:0]      C_BIRD_L    = 12'(BIRD_X);
  localparam logic [11:0]      C_BIRD_R    = 12'(BIRD_X + BIRD_SIZE - 1);
  localparam logic [11:0]      C_BIRD_SZ   = 12'(BIRD_SIZE);
  localparam logic [11:0]      C_FLOOR     = 12'(SCREEN_H);
  localparam logic [11:0]      C_PIPE_W    = 12'(PIPE_W);
  localparam logic [11:0]      C_PIPE_W1   = 12'(PIPE_W - 1);
  localparam logic [11:0]      C_GAP_H     = 12'(GAP_H);
  localparam logic [11:0]      C_SPEED     = 12'(SPEED);
  // A respawned pipe lands one full spacing behind the current last pipe.
  localparam logic [11:0]      C_WRAP_ADJ  = 12'(N_PIPES * PIPE_SPACING - SPEED);
  localparam logic [9:0]       C_GAP_RST   = 10'(SCREEN_H / 2 - GAP_H / 2);
  localparam logic [9:0]       C_GAP_MIN   = 10'(GAP_MARGIN);
  localparam logic [SUM_W-1:0] C_SCORE_MAX = SUM_W'((1 << SCORE_W) - 1);

  // Registered state
  state_t                     r_state;
  logic                       r_start_q;
  logic [15:0]                r_lfsr;
  logic [N_PIPES-1:0][10:0]   r_pipe_x;
  logic [N_PIPES-1:0][9:0]    r_pipe_gap;
  logic [SCORE_W-1:0]         r_score;
  logic                       r_collided;

  // Combinational signals
  state_t                     w_state_nxt;
  logic                       w_start_edge;
  logic [11:0]                w_bird_top;
  logic [11:0]                w_bird_bot;
  logic                       w_floor;
  logic [N_PIPES-1:0]         w_pipe_hit;
  logic                       w_hit;
  logic [N_PIPES-1:0][11:0]   w_px;
  logic [N_PIPES-1:0][11:0]   w_gt;
  logic [N_PIPES-1:0][10:0]   w_rst_x;
  logic [N_PIPES-1:0][10:0]   w_pipe_x_nxt;
  logic [N_PIPES-1:0][9:0]    w_pipe_gap_nxt;
  logic [N_PIPES-1:0]         w_pass;
  logic [CW-1:0]              w_pass_cnt;
  logic [SUM_W-1:0]           w_score_sum;
  logic [SCORE_W-1:0]         w_score_nxt;
  logic [15:0]                w_lfsr_nxt;

  assign w_start_edge = start & ~r_start_q;
  assign w_bird_top   = {2'b00, bird_y};
  assign w_bird_bot   = w_bird_top + C_BIRD_SZ;
  assign w_floor      = w_bird_bot > C_FLOOR;

  for (genvar g = 0; g < N_PIPES; g++) begin : g_pipe
    assign w_px[g]    = {1'b0, r_pipe_x[g]};
    assign w_gt[g]    = {2'b00, r_pipe_gap[g]};
    assign w_rst_x[g] = 11'(SCREEN_W + g * PIPE_SPACING);
  end

  // Collision: horizontal overlap with a pipe while any part of the bird is
  // outside that pipe's gap.
  always_comb begin
    w_pipe_hit = '0;
    for (int i = 0; i < N_PIPES; i++) begin
      w_pipe_hit[i] = (w_px[i] <= C_BIRD_R) &&
                      (w_px[i] + C_PIPE_W1 >= C_BIRD_L) &&
                      ((w_bird_top < w_gt[i]) || (w_bird_bot > w_gt[i] + C_GAP_H));
    end
  end

  assign w_hit = w_floor | (|w_pipe_hit);

  // Fibonacci LFSR, taps 16,14,13,11 (bit indices 15,13,12,10).
  assign w_lfsr_nxt = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};

  // Per-pipe scroll/respawn. All respawns in one step share the pre-step LFSR value.
  always_comb begin
    w_pipe_x_nxt   = r_pipe_x;
    w_pipe_gap_nxt = r_pipe_gap;
    w_pass         = '0;
    for (int i = 0; i < N_PIPES; i++) begin
      if (w_px[i] < C_SPEED) begin
        w_pipe_x_nxt[i]   = 11'(w_px[i] + C_WRAP_ADJ);
        w_pipe_gap_nxt[i] = C_GAP_MIN + {2'b00, r_lfsr[7:0]};
      end else begin
        w_pipe_x_nxt[i]   = 11'(w_px[i] - C_SPEED);
      end
      // A pipe is passed when its right edge crosses the bird's left edge.
      w_pass[i] = (w_px[i] + C_PIPE_W >= C_BIRD_L) &&
                  ({1'b0, w_pipe_x_nxt[i]} + C_PIPE_W < C_BIRD_L);
    end
  end

  // Saturating score update
  always_comb begin
    w_pass_cnt = '0;
    for (int i = 0; i < N_PIPES; i++) begin
      w_pass_cnt = w_pass_cnt + CW'(w_pass[i]);
    end
    w_score_sum = SUM_W'(r_score) + SUM_W'(w_pass_cnt);
    w_score_nxt = (w_score_sum > C_SCORE_MAX) ? SCORE_W'(C_SCORE_MAX) : SCORE_W'(w_score_sum);
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    if (w_start_edge) w_state_nxt = ST_PLAYING;
      ST_PLAYING: if (w_hit)        w_state_nxt = ST_OVER;
      ST_OVER:    if (w_start_edge) w_state_nxt = ST_IDLE;
      default:                      w_state_nxt = ST_IDLE;
    endcase
  end

  // Game datapath
  always_ff @(posedge clk) begin
    if (reset) begin
      r_start_q  <= 1'b0;
      r_lfsr     <= LFSR_SEED;
      r_pipe_x   <= w_rst_x;
      r_pipe_gap <= {N_PIPES{C_GAP_RST}};
      r_score    <= '0;
      r_collided <= 1'b0;
    end else begin
      r_start_q <= start;
      case (r_state)
        ST_IDLE: begin
          // New game: pipes and score restart; the LFSR keeps running.
          if (w_start_edge) begin
            r_pipe_x   <= w_rst_x;
            r_pipe_gap <= {N_PIPES{C_GAP_RST}};
            r_score    <= '0;
            r_collided <= 1'b0;
          end
        end
        ST_PLAYING: begin
          // Collision has priority over a coincident tick: the pipes freeze.
          if (w_hit) begin
            r_collided <= 1'b1;
          end else if (tick) begin
            r_lfsr     <= w_lfsr_nxt;
            r_pipe_x   <= w_pipe_x_nxt;
            r_pipe_gap <= w_pipe_gap_nxt;
            r_score    <= w_score_nxt;
          end
        end
        default: ;
      endcase
    end
  end

  assign pipe_x       = r_pipe_x;
  assign pipe_gap_top = r_pipe_gap;
  assign state        = r_state;
  assign score        = r_score;
  assign collided     = r_collided;

endmodule
